// File: rtl/bus_responder_if.sv
// Address/strobe/status/READY bundle of the 8080-style bus seen by one target.
interface bus_responder_if;
  logic [15:0] ADD;
  logic        RDn;
  logic        WRn;
  logic        IO_Mn;
  logic        S0;
  logic        S1;
  logic        READY;

  modport master (output ADD, RDn, WRn, IO_Mn, S0, S1, input READY);
  modport slave  (input ADD, RDn, WRn, IO_Mn, S0, S1, output READY);
endinterface

// File: rtl/bus_responder.sv
// Memory/IO target for the 8080-style bus: byte RAM window plus one IO register,
// with a programmable number of READY wait states per selected access.
module bus_responder #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  IO_PORT     = 8'h00
) (
  input  logic           clock,
  input  logic           resetn,
  bus_responder_if.slave bus,
  inout  wire  [7:0]     DATA,
  output logic [7:0]     io_reg,
  output logic           hit,
  output logic           access_err
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {IDLE, WAITST, RDRIVE, WDONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            io_q, io_d;
  logic            wr_q, wr_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      io_reg_d;
  logic            ready_q, ready_d;
  logic            hit_d, err_d;
  logic            strobes_idle_q;

  logic [7:0]      mem [DEPTH];

  logic [16:0]     add_x, base_x, top_x;
  logic            mem_sel_c, io_sel_c, sel_c;
  logic            rd_c, wr_c, both_c;
  logic [AW-1:0]   idx_c;
  logic            done_c, done_wr_c, done_io_c;
  logic [AW-1:0]   done_idx_c;
  logic            mem_we_c;
  logic            unused_status;

  // 17-bit window compare so a window ending at 16'hFFFF never wraps
  assign add_x     = {1'b0, bus.ADD};
  assign base_x    = {1'b0, ADDR_BASE};
  assign top_x     = base_x + 17'(DEPTH);
  assign mem_sel_c = !bus.IO_Mn && (add_x >= base_x) && (add_x < top_x);
  assign io_sel_c  = bus.IO_Mn && (bus.ADD[7:0] == IO_PORT);
  assign sel_c     = mem_sel_c || io_sel_c;
  assign idx_c     = AW'(bus.ADD - ADDR_BASE);

  assign rd_c   = !bus.RDn &&  bus.WRn;
  assign wr_c   =  bus.RDn && !bus.WRn;
  assign both_c = !bus.RDn && !bus.WRn;

  assign unused_status = bus.S0 ^ bus.S1;

  // Next-state, completion and error logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    io_d       = io_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    io_reg_d   = io_reg;
    ready_d    = 1'b1;
    err_d      = 1'b0;
    done_c     = 1'b0;
    done_wr_c  = wr_q;
    done_io_c  = io_q;
    done_idx_c = idx_q;
    mem_we_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_c && both_c) begin
          err_d = 1'b1;
        end else if (sel_c && strobes_idle_q && (rd_c || wr_c)) begin
          idx_d = idx_c;
          io_d  = io_sel_c;
          wr_d  = wr_c;
          if (WAIT_STATES > 0) begin
            state_d = WAITST;
            cnt_d   = CW'(WAIT_STATES - 1);
            ready_d = 1'b0;
          end else begin
            done_c     = 1'b1;
            done_wr_c  = wr_c;
            done_io_c  = io_sel_c;
            done_idx_c = idx_c;
          end
        end
      end
      WAITST: begin
        if (both_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          done_c = 1'b1;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          ready_d = 1'b0;
        end
      end
      RDRIVE: begin
        if (both_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.RDn) begin
          state_d = IDLE;
        end
      end
      WDONE: begin
        if (both_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (bus.WRn) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_c) begin
      if (done_wr_c) begin
        state_d = WDONE;
        if (done_io_c) io_reg_d = DATA;
        else           mem_we_c = 1'b1;
      end else begin
        state_d = RDRIVE;
        rdata_d = done_io_c ? io_reg : mem[done_idx_c];
      end
    end

    hit_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      io_q           <= 1'b0;
      wr_q           <= 1'b0;
      rdata_q        <= 8'h00;
      io_reg         <= 8'h00;
      ready_q        <= 1'b1;
      hit            <= 1'b0;
      access_err     <= 1'b0;
      strobes_idle_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      io_q           <= io_d;
      wr_q           <= wr_d;
      rdata_q        <= rdata_d;
      io_reg         <= io_reg_d;
      ready_q        <= ready_d;
      hit            <= hit_d;
      access_err     <= err_d;
      strobes_idle_q <= bus.RDn && bus.WRn;
    end
  end

  // RAM has no reset; a reset edge suppresses any pending write
  always_ff @(posedge clock) begin
    if (resetn && mem_we_c) mem[done_idx_c] <= DATA;
  end

  assign bus.READY = ready_q;
  assign DATA      = (state_q == RDRIVE) ? rdata_q : 8'hzz;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench: five responders with different windows/wait states,
// a vector table of accesses, a read-data scoreboard and corner-case sequences.
module tb_bus_responder;

  localparam int unsigned ND = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] add;
  logic        rdn, wrn, io_mn;
  logic        tb_oe;
  logic [7:0]  tb_data;
  int          cur;

  logic [ND-1:0]        ready_o, hit_o, err_o;
  logic [ND-1:0][7:0]   io_reg_o, data_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] mdl_mem [ND][1024];
  logic [7:0] mdl_io  [ND];
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : gen_dut
    localparam int unsigned NW   = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : (g == 3) ? 15 : 1;
    localparam logic [15:0] BASE = (g == 4) ? 16'hFC00 : 16'h0000;

    bus_responder_if bus ();
    tri1 [7:0] d;

    assign bus.ADD   = add;
    assign bus.IO_Mn = io_mn;
    assign bus.S0    = 1'b0;
    assign bus.S1    = 1'b0;
    assign bus.RDn   = (cur == g) ? rdn : 1'b1;
    assign bus.WRn   = (cur == g) ? wrn : 1'b1;
    assign d         = (tb_oe && cur == g) ? tb_data : 8'hzz;

    bus_responder #(.ADDR_BASE(BASE), .AW(10), .WAIT_STATES(NW), .IO_PORT(8'h42)) dut (
      .clock      (clk),
      .resetn     (resetn),
      .bus        (bus),
      .DATA       (d),
      .io_reg     (io_reg_o[g]),
      .hit        (hit_o[g]),
      .access_err (err_o[g])
    );

    assign ready_o[g] = bus.READY;
    assign data_o[g]  = d;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] model_idx(input int k, input logic [15:0] a);
    logic [15:0] base;
    base = (k == 4) ? 16'hFC00 : 16'h0000;
    return 10'(a - base);
  endfunction

  // One complete access; released DATA reads as 8'hFF through the pull-up
  task automatic access(input int k, input bit wr, input bit io, input logic [15:0] a,
                        input logic [7:0] wd, input bit sel, input int nw, input string nm);
    int waits;
    logic [9:0] ix;
    ix = model_idx(k, a);
    @(negedge clk);
    cur = k; add = a; io_mn = io;
    if (wr) begin tb_data = wd; tb_oe = 1'b1; wrn = 1'b0; end
    else rdn = 1'b0;
    if (sel) begin
      if (wr) begin
        if (io) mdl_io[k] = wd; else mdl_mem[k][ix] = wd;
      end else begin
        sb.push_back(io ? mdl_io[k] : mdl_mem[k][ix]);
      end
      waits = 0;
      @(negedge clk);
      while (!ready_o[k] && waits < 40) begin
        check({nm, " hit during wait"}, 32'(hit_o[k]), 32'd1);
        waits++;
        @(negedge clk);
      end
      check({nm, " wait cycles"}, 32'(waits), 32'(nw));
      check({nm, " hit"}, 32'(hit_o[k]), 32'd1);
      if (!wr) begin
        if (sb.size() > 0) check({nm, " read data"}, 32'(data_o[k]), 32'(sb.pop_front()));
        else check({nm, " scoreboard empty"}, 32'd0, 32'd1);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check({nm, " unsel ready"}, 32'(ready_o[k]), 32'd1);
        check({nm, " unsel hit"}, 32'(hit_o[k]), 32'd0);
        if (!wr) check({nm, " unsel data z"}, 32'(data_o[k]), 32'hFF);
      end
    end
    rdn = 1'b1; wrn = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
    check({nm, " released data"}, 32'(data_o[k]), 32'hFF);
    check({nm, " idle hit"}, 32'(hit_o[k]), 32'd0);
    check({nm, " idle ready"}, 32'(ready_o[k]), 32'd1);
    check({nm, " io_reg"}, 32'(io_reg_o[k]), 32'(mdl_io[k]));
  endtask

  typedef struct {
    int          k;
    bit          wr;
    bit          io;
    logic [15:0] a;
    logic [7:0]  wd;
    bit          sel;
    int          nw;
  } vec_t;

  vec_t vecs [20];

  initial begin
    vecs[0]  = '{0, 1'b1, 1'b0, 16'h0010, 8'hA5, 1'b1, 1};
    vecs[1]  = '{0, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, 1};
    vecs[2]  = '{0, 1'b1, 1'b1, 16'h0042, 8'h3C, 1'b1, 1};
    vecs[3]  = '{0, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, 1};
    vecs[4]  = '{0, 1'b1, 1'b1, 16'h0043, 8'h5A, 1'b0, 0};
    vecs[5]  = '{0, 1'b0, 1'b1, 16'h0042, 8'h00, 1'b1, 1};
    vecs[6]  = '{1, 1'b1, 1'b0, 16'h0020, 8'h11, 1'b1, 0};
    vecs[7]  = '{1, 1'b0, 1'b0, 16'h0020, 8'h00, 1'b1, 0};
    vecs[8]  = '{2, 1'b1, 1'b0, 16'h0030, 8'h22, 1'b1, 3};
    vecs[9]  = '{2, 1'b0, 1'b0, 16'h0030, 8'h00, 1'b1, 3};
    vecs[10] = '{3, 1'b1, 1'b0, 16'h0040, 8'h33, 1'b1, 15};
    vecs[11] = '{3, 1'b0, 1'b0, 16'h0040, 8'h00, 1'b1, 15};
    vecs[12] = '{4, 1'b1, 1'b0, 16'hFC00, 8'h44, 1'b1, 1};
    vecs[13] = '{4, 1'b1, 1'b0, 16'hFFFF, 8'h55, 1'b1, 1};
    vecs[14] = '{4, 1'b0, 1'b0, 16'hFC00, 8'h00, 1'b1, 1};
    vecs[15] = '{4, 1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b1, 1};
    vecs[16] = '{4, 1'b1, 1'b0, 16'hFBFF, 8'h66, 1'b0, 0};
    vecs[17] = '{4, 1'b0, 1'b0, 16'hFBFF, 8'h00, 1'b0, 0};
    vecs[18] = '{0, 1'b0, 1'b0, 16'h0400, 8'h00, 1'b0, 0};
    vecs[19] = '{4, 1'b0, 1'b0, 16'hFFFF, 8'h00, 1'b1, 1};

    for (int k = 0; k < ND; k++) mdl_io[k] = 8'h00;
    resetn = 1'b0; rdn = 1'b1; wrn = 1'b1; io_mn = 1'b0; add = 16'h0000;
    tb_oe = 1'b0; tb_data = 8'h00; cur = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("reset ready d%0d", k), 32'(ready_o[k]), 32'd1);
      check($sformatf("reset hit d%0d", k), 32'(hit_o[k]), 32'd0);
      check($sformatf("reset err d%0d", k), 32'(err_o[k]), 32'd0);
      check($sformatf("reset io_reg d%0d", k), 32'(io_reg_o[k]), 32'd0);
      check($sformatf("reset data d%0d", k), 32'(data_o[k]), 32'hFF);
    end
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++)
      access(vecs[i].k, vecs[i].wr, vecs[i].io, vecs[i].a, vecs[i].wd,
             vecs[i].sel, vecs[i].nw, $sformatf("v%0d", i));

    // Both strobes low during WAITST: abort with no write
    access(2, 1'b1, 1'b0, 16'h0050, 8'h77, 1'b1, 3, "pre err");
    @(negedge clk);
    cur = 2; add = 16'h0050; io_mn = 1'b0; tb_data = 8'h99; tb_oe = 1'b1; wrn = 1'b0;
    @(negedge clk);
    check("ws err ready low", 32'(ready_o[2]), 32'd0);
    check("ws err hit", 32'(hit_o[2]), 32'd1);
    rdn = 1'b0;
    @(negedge clk);
    check("ws err pulse", 32'(err_o[2]), 32'd1);
    check("ws err ready", 32'(ready_o[2]), 32'd1);
    check("ws err hit idle", 32'(hit_o[2]), 32'd0);
    rdn = 1'b1; wrn = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
    check("ws err pulse end", 32'(err_o[2]), 32'd0);
    access(2, 1'b0, 1'b0, 16'h0050, 8'h00, 1'b1, 3, "ws err readback");

    // Both strobes low in IDLE, then RDn left low alone: no request taken
    @(negedge clk);
    cur = 0; add = 16'h0010; io_mn = 1'b0; rdn = 1'b0; wrn = 1'b0;
    @(negedge clk);
    check("idle err pulse", 32'(err_o[0]), 32'd1);
    check("idle err hit", 32'(hit_o[0]), 32'd0);
    check("idle err ready", 32'(ready_o[0]), 32'd1);
    wrn = 1'b1;
    @(negedge clk);
    check("idle err cleared", 32'(err_o[0]), 32'd0);
    check("stale rd no req 1", 32'(hit_o[0]), 32'd0);
    @(negedge clk);
    check("stale rd no req 2", 32'(hit_o[0]), 32'd0);
    rdn = 1'b1;
    @(negedge clk);

    // Write whose WRn release coincides with RDn going low: not a new read
    cur = 1; add = 16'h0060; io_mn = 1'b0; tb_data = 8'h12; tb_oe = 1'b1; wrn = 1'b0;
    mdl_mem[1][10'h060] = 8'h12;
    @(negedge clk);
    check("b2b wdone hit", 32'(hit_o[1]), 32'd1);
    wrn = 1'b1; rdn = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    check("b2b idle hit", 32'(hit_o[1]), 32'd0);
    @(negedge clk);
    check("b2b no req hit", 32'(hit_o[1]), 32'd0);
    check("b2b no drive", 32'(data_o[1]), 32'hFF);
    rdn = 1'b1;
    @(negedge clk);
    access(1, 1'b0, 1'b0, 16'h0060, 8'h00, 1'b1, 0, "b2b readback");

    // Reset while driving read data
    @(negedge clk);
    cur = 0; add = 16'h0010; io_mn = 1'b0; rdn = 1'b0;
    sb.push_back(mdl_mem[0][10'h010]);
    @(negedge clk);
    check("rst rd ready low", 32'(ready_o[0]), 32'd0);
    @(negedge clk);
    check("rst rd ready", 32'(ready_o[0]), 32'd1);
    if (sb.size() > 0) check("rst rd data", 32'(data_o[0]), 32'(sb.pop_front()));
    else check("rst rd scoreboard empty", 32'd0, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    for (int k = 0; k < ND; k++) mdl_io[k] = 8'h00;
    check("rst mid data z", 32'(data_o[0]), 32'hFF);
    check("rst mid ready", 32'(ready_o[0]), 32'd1);
    check("rst mid hit", 32'(hit_o[0]), 32'd0);
    check("rst mid io_reg", 32'(io_reg_o[0]), 32'd0);
    resetn = 1'b1; rdn = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, 1, "post rst ram");
    access(0, 1'b0, 1'b1, 16'h0042, 8'h00, 1'b1, 1, "post rst io");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory/IO target for the 8080-style bus that `cpu8080` masters: decodes `ADD`/`IO_Mn`, answers `RDn` reads by driving `DATA`, captures `WRn` writes into internal byte RAM or a single IO register, and throttles the master with a programmable number of wait states on `READY`. One instance sits on the shared `DATA`/`ADD` bus. It provides the program/data store and one output port the CPU runs against in simulation and on FPGA.

## Interface
- `ADDR_BASE`, 16'h0000: first byte address of the RAM window.
- `AW`, 10: RAM address width. Depth is 2**AW bytes.
- `WAIT_STATES`, 1: `READY`-low cycles inserted per selected access, 0..15.
- `IO_PORT`, 8'h00: IO address (`ADD[7:0]`) of the output register.
- `clock`  in  1  single clock; all state changes on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `ADD`  in  16  address from master.
- `DATA`  inout  8  bidirectional data. Driven only in read-drive state, else Z.
- `RDn`  in  1  active-low read strobe.
- `WRn`  in  1  active-low write strobe.
- `IO_Mn`  in  1  1 = IO cycle, 0 = memory cycle.
- `S0`, `S1`  in  1 each  status. Monitored only, no effect on decode.
- `READY`  out  1  0 = master must wait.
- `io_reg`  out  8  current IO register value.
- `hit`  out  1  high while an access to this block is in progress (any non-IDLE state).
- `access_err`  out  1  one-cycle pulse on protocol error.

## Operation
- Memory select: `IO_Mn`=0 and `ADDR_BASE` <= `ADD` < `ADDR_BASE`+2**AW. The compare is 17-bit, so there is no wrap at 16'hFFFF. Index = (`ADD`-`ADDR_BASE`)[AW-1:0].
- IO select: `IO_Mn`=1 and `ADD[7:0]`==`IO_PORT`.
- FSM states: IDLE, WAITST, RDRIVE, WDONE.
- IDLE:
  - Request = selected and exactly one of `RDn`/`WRn` low.
  - On a request, latch address, space (mem/io) and direction.
  - If `WAIT_STATES`>0: go to WAITST, load counter = `WAIT_STATES`-1, `READY`<=0.
  - Else: complete the access immediately (see below).
- WAITST: decrement each cycle. At 0, complete the access and set `READY`<=1.
- Completion, read: `rdata`<=mem[idx] or `io_reg`; go to RDRIVE.
- Completion, write: sample `DATA` on that edge, write mem[idx] or `io_reg`; go to WDONE.
- RDRIVE: `DATA`=`rdata` while `RDn`=0. When `RDn` is sampled 1, release `DATA` and go to IDLE.
- WDONE: when `WRn` is sampled 1, go to IDLE.
- Unselected cycles: `READY` stays 1, `DATA` stays Z, no state change.
- `ADD`/`IO_Mn` changes after the request is latched are ignored until return to IDLE.
- Protocol error: `RDn`=0 and `WRn`=0 together.
  - In IDLE while selected: pulse `access_err`, no request taken.
  - In any other state: pulse `access_err`, abort to IDLE, `READY`<=1, `DATA` released, no write if not yet done.
- Back-to-back accesses: a strobe still low on return to IDLE is not a new request. A new request needs both strobes to have been high for at least one sampled cycle.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - FSM goes to IDLE, `READY`=1, `DATA`=Z, `hit`=0, `access_err`=0, `io_reg`=8'h00.
  - RAM contents are preserved.
  - A reset mid-access aborts it with no write. `DATA` is released on the reset edge.
- Read latency with N=`WAIT_STATES`, from the edge where the request is sampled in IDLE:
  - N=0: `DATA` is valid after edge 1.
  - N>0: `READY` is low after edges 1..N. `READY`=1 and `DATA` are valid after edge N+1.
- Write latency: the write occurs at edge N+1 (edge 1 if N=0), using `DATA` sampled at that edge. The master must hold `DATA` through that edge.
- `READY` is low for exactly N cycles per selected access. It is never low when `hit`=0.
- Turnaround: `DATA` returns to Z one cycle after `RDn` is sampled high.

## Test plan
- Write then read, N=1: write 8'hA5 to 16'h0010, then read 16'h0010. Expect `READY` low exactly 1 cycle on each access and `DATA`=8'hA5 on the read.
- Wait-state sweep N=0,3,15: read any address. Expect `READY`-low duration = N cycles and `DATA` valid at edge N+1.
- IO port: with `IO_PORT`=8'h42, IO write 8'h3C to port 8'h42. Expect `io_reg`=8'h3C and RAM unchanged. IO write to 8'h43: no response, `READY`=1, `DATA`=Z.
- Window edges, `ADDR_BASE`=16'hFC00, AW=10:
  - Accesses at 16'hFC00 and 16'hFFFF hit, indices 0 and 1023.
  - An access at 16'hFBFF is ignored.
- Protocol error: drive `RDn`=`WRn`=0 during WAITST. Expect an `access_err` pulse, return to IDLE, `READY`=1, and no RAM write.
- Reset mid-read in RDRIVE: expect `DATA`=Z and `READY`=1 after the reset edge, `io_reg`=0, and a prior RAM write still readable after reset.
